sram_ctrl: RTL
==============

// Module: sram_ctrl
// PURPOSE
//  Bus slave sitting directly downstream of the MMU on the physical memory bus. Converts one
//  MMU request (ce/addr/data/we/select) into an asynchronous-SRAM read or write cycle with
//  programmable wait states, then returns read data and a one-cycle ack. Serves device slot
//  DEV_BIT of the 16-bit select; requests for other slots are ignored (another slave answers).
// PARAMETERS
//  ADDR_W       20  SRAM word-address width; physical byte addr[ADDR_W+1:2] drives the pins
//  WAIT_CYCLES  2   cycles OE_n/WE_n held active (legal 1..15)
//  DEV_BIT      4   select bit that claims a request for this slave
// PORTS
//  clk           in   1       system clock; all state updates on rising edge
//  rst           in   1       asynchronous reset, active-low
//  bus_ce_i      in   1       request valid (from MMU)
//  bus_addr_i    in   32      physical byte address
//  bus_data_i    in   32      write data
//  bus_we_i      in   1       1 = write, 0 = read
//  bus_select_i  in   16      [3:0] byte enables (bit3 = data[31:24]), [15:4] one-hot device select
//  bus_data_o    out  32      read data; valid when bus_ack_o = 1
//  bus_ack_o     out  1       one-cycle completion pulse
//  sram_addr_o   out  ADDR_W  SRAM word address
//  sram_dq_o     out  32      SRAM write data (pad tristate lives at the top level)
//  sram_dq_i     in   32      SRAM read data
//  sram_dq_oe    out  1       1 = drive sram_dq_o onto the pads
//  sram_ce_n     out  1       chip enable, active-low
//  sram_oe_n     out  1       output enable, active-low
//  sram_we_n     out  1       write enable, active-low
//  sram_be_n     out  4       byte enables, active-low (= ~bus_select_i[3:0], latched)
// BEHAVIOUR
//  Reset (rst = 0, async): state IDLE, wait counter 0. bus_ack_o = 0, bus_data_o = 0,
//   sram_ce_n/oe_n/we_n = 1, sram_be_n = 4'hF, sram_dq_oe = 0, sram_addr_o = 0, sram_dq_o = 0.
//   Reset mid-transaction aborts it: no ack; SRAM controls return to inactive immediately.
//  Request claim: in IDLE, a rising edge with bus_ce_i = 1 && bus_select_i[DEV_BIT] = 1
//   latches addr/data/we/byte enables, then moves to SETUP. After the claim, inputs are not
//   re-sampled. Dropping bus_ce_i mid-cycle does not abort; the cycle completes and acks.
//  FSM states:
//   IDLE   : all SRAM controls inactive, dq_oe = 0.
//   SETUP  : 1 cycle; ce_n = 0, addr and be_n valid. For writes, dq_oe = 1 and dq_o valid.
//            Next state is ACCESS. Counter loads WAIT_CYCLES-1.
//   ACCESS : WAIT_CYCLES cycles; read drives oe_n = 0, write drives we_n = 0.
//            Counter decrements each cycle; leave the state when the counter reaches 0.
//            Read: on the last ACCESS edge, capture sram_dq_i into bus_data_o, then go to ACK.
//            Write: go to HOLD.
//   HOLD   : write only, 1 cycle; we_n = 1 while ce_n, addr and dq stay held (data hold time).
//            Next state is ACK.
//   ACK    : 1 cycle; bus_ack_o = 1, all SRAM controls inactive, dq_oe = 0. Next state is IDLE.
//  Latency (claim edge = cycle 0): read ack in cycle 2+WAIT_CYCLES; write ack in cycle 3+WAIT_CYCLES.
//  Back-to-back: the earliest next claim is the edge ending the ACK cycle's successor IDLE cycle.
//   The MMU updates its request on that edge, so a stale request is never re-serviced.
//  bus_data_o holds the last read value until the next read capture. Writes never modify it.
//  Address bits above ADDR_W+1 are ignored (SRAM space aliases). addr[1:0] is ignored.
//  Byte enables 4'b0000 with a write: full timing is still run with be_n = 4'hF, and the cycle acks.
//  A read with partial byte enables returns the full 32-bit word; the MMU merges bytes.
//  More than one device bit set with DEV_BIT among them: claim anyway (decode error belongs to the MMU).
//  dq_oe and oe_n are never both active in the same cycle (no bus contention).
// STRUCTURE
//  defines.v holds: SRAM FSM state encodings (`SRAM_IDLE .. `SRAM_ACK), the select field layout
//   (byte-enable slice, device-bit numbering, `WB_SELECT_ZERO), and the RstEnable/NoStop-style
//   constants already in use.
//  Single module, no sub-module: FSM, 4-bit wait counter, and latched request/read-data
//   registers. The inout pad buffer is instantiated at the top level, not here.
// TESTING
//  1 Reset: hold rst = 0 during a write in ACCESS -> outputs return to reset values within
//    the same cycle; no ack.
//  2 Read, WAIT_CYCLES = 2: addr 0x0000_0010, sel 16'h001F, sram_dq_i = 0xDEADBEEF ->
//    sram_addr_o = 4, oe_n low 2 cycles, ack in cycle 4, bus_data_o = 0xDEADBEEF.
//  3 Byte write: addr 0x0000_0100, data 0x1122_3344, sel 16'h0012 -> be_n = 4'hD,
//    we_n low 2 cycles, 1 HOLD cycle with dq held, ack in cycle 5.
//  4 Foreign slot: sel 16'h0020 with ce = 1 for 10 cycles -> no SRAM activity, no ack.
//  5 Back-to-back write then read: next request presented the cycle after ack -> claimed
//    exactly once each, bus_data_o unchanged by the write.
//  6 ce dropped in SETUP -> cycle still completes and acks; WAIT_CYCLES = 1 and 15 both
//    give the latencies above.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM bus slave: FSM states, select-field
// layout and the device-slot decode helper.
package sram_ctrl_pkg;

  localparam int unsigned BUS_W    = 32;
  localparam int unsigned SELECT_W = 16;
  localparam int unsigned BE_W     = 4;

  localparam logic [SELECT_W-1:0] SELECT_ZERO = '0;
  localparam logic [BE_W-1:0]     BE_N_NONE   = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD,
    ST_ACK
  } sram_state_t;

  function automatic logic [SELECT_W-1:0] dev_mask(input int unsigned dev_bit);
    return SELECT_W'(1) << dev_bit;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// MMU-side physical memory bus: request from the master, read data and ack back.
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  logic                bus_ce_i;
  logic [BUS_W-1:0]    bus_addr_i;
  logic [BUS_W-1:0]    bus_data_i;
  logic                bus_we_i;
  logic [SELECT_W-1:0] bus_select_i;
  logic [BUS_W-1:0]    bus_data_o;
  logic                bus_ack_o;

  modport master (
    output bus_ce_i, bus_addr_i, bus_data_i, bus_we_i, bus_select_i,
    input  bus_data_o, bus_ack_o
  );

  modport slave (
    input  bus_ce_i, bus_addr_i, bus_data_i, bus_we_i, bus_select_i,
    output bus_data_o, bus_ack_o
  );

endinterface

// File: rtl/sram_ctrl.sv
// Async-SRAM bus slave: one claimed request becomes one SRAM read/write cycle with
// WAIT_CYCLES strobe width (legal 1..15), followed by a one-cycle ack.
//   state  | meaning
//   IDLE   | controls inactive, waiting for a request with our device bit
//   SETUP  | ce_n low, addr/be_n (and write data) presented
//   ACCESS | oe_n (read) or we_n (write) low for WAIT_CYCLES cycles
//   HOLD   | write only: we_n released, ce/addr/dq held for data hold time
//   ACK    | controls inactive, bus_ack_o high
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEV_BIT     = 4
) (
  input  logic              clk,
  input  logic              rst,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [BUS_W-1:0]  sram_dq_o,
  input  logic [BUS_W-1:0]  sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [BE_W-1:0]   sram_be_n
);

  localparam logic [3:0]          WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [SELECT_W-1:0] DEV_MASK  = dev_mask(DEV_BIT);

  sram_state_t state;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic        claim;
  logic        unused_bus_bits;

  // Multiple device bits are claimed as long as ours is among them.
  assign claim = bus.bus_ce_i && ((bus.bus_select_i & DEV_MASK) != SELECT_ZERO);

  // Upper address bits alias and select bits other than ours belong to other slaves.
  assign unused_bus_bits = ^{bus.bus_addr_i, bus.bus_select_i};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      wait_cnt       <= '0;
      we_q           <= 1'b0;
      bus.bus_ack_o  <= 1'b0;
      bus.bus_data_o <= '0;
      sram_addr_o    <= '0;
      sram_dq_o      <= '0;
      sram_dq_oe     <= 1'b0;
      sram_ce_n      <= 1'b1;
      sram_oe_n      <= 1'b1;
      sram_we_n      <= 1'b1;
      sram_be_n      <= BE_N_NONE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (claim) begin
            state       <= ST_SETUP;
            we_q        <= bus.bus_we_i;
            sram_addr_o <= bus.bus_addr_i[ADDR_W+1:2];
            sram_dq_o   <= bus.bus_data_i;
            sram_be_n   <= ~bus.bus_select_i[BE_W-1:0];
            sram_ce_n   <= 1'b0;
            sram_dq_oe  <= bus.bus_we_i;
          end
        end

        ST_SETUP: begin
          state     <= ST_ACCESS;
          wait_cnt  <= WAIT_LOAD;
          sram_oe_n <= we_q;
          sram_we_n <= ~we_q;
        end

        ST_ACCESS: begin
          if (wait_cnt == 4'd0) begin
            if (we_q) begin
              state     <= ST_HOLD;
              sram_we_n <= 1'b1;
            end else begin
              state          <= ST_ACK;
              bus.bus_data_o <= sram_dq_i;
              bus.bus_ack_o  <= 1'b1;
              sram_oe_n      <= 1'b1;
              sram_ce_n      <= 1'b1;
              sram_be_n      <= BE_N_NONE;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        ST_HOLD: begin
          state         <= ST_ACK;
          bus.bus_ack_o <= 1'b1;
          sram_ce_n     <= 1'b1;
          sram_dq_oe    <= 1'b0;
          sram_be_n     <= BE_N_NONE;
        end

        ST_ACK: begin
          // No claim here: the MMU replaces its request on this edge.
          state         <= ST_IDLE;
          bus.bus_ack_o <= 1'b0;
        end

        default: begin
          state         <= ST_IDLE;
          bus.bus_ack_o <= 1'b0;
          sram_dq_oe    <= 1'b0;
          sram_ce_n     <= 1'b1;
          sram_oe_n     <= 1'b1;
          sram_we_n     <= 1'b1;
          sram_be_n     <= BE_N_NONE;
        end
      endcase
    end
  end

endmodule
